clock_seq_ctrl: RTL and testbench
=================================

Name: clock_seq_ctrl

Overview:
- Single-clock-domain sequencer for the min:sec clock/alarm datapath.
- Replaces gated/ripple count clocks with one-cycle increment enables.
- Debounces the four front-panel keys and runs the mode/position FSM, the 1 Hz tick, setup auto-repeat and alarm ringing.
- Sits between the key pins and the sec/min/alarm counters, the display mux and the buzzer.

Parameters:
- TICK_DIV, 50000000: clk cycles per 1 s tick.
- DEB_CNT, 1000000: cycles a synchronised key level must stay stable before it is accepted (20 ms).
- RPT_DLY, 25000000: hold time before the first auto-repeat of sw2.
- RPT_PER, 5000000: auto-repeat period after the first repeat.
- RING_TICKS, 60: ticks the alarm rings before self-stop.
- SNOOZE_TICKS, 300: snooze length in ticks (CLK_SEQ_SNOOZE_EN only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_sw0..i_sw3  in  1 each  raw keys, active-low: mode, position, increment, alarm-enable
- i_sec_max  in  1  seconds counter currently at 59
- i_alarm_match  in  1  time equals alarm time (level)
- o_mode  out  2  00 CLOCK, 01 SETUP, 10 ALARM
- o_position  out  1  0 SEC, 1 MIN
- o_alarm_en  out  1  alarm armed
- o_sec_inc, o_min_inc  out  1 each  time counter increment enables, one-cycle pulses
- o_alarm_sec_inc, o_alarm_min_inc  out  1 each  alarm counter increment enables, one-cycle pulses
- o_buzz_en  out  1  buzzer enable

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All state clears on reset: o_mode=00, o_position=0, o_alarm_en=0, all *_inc=0, o_buzz_en=0, tick counter=0, debounced key state=released.
- Key path, per key:
  - 2-flop synchroniser, then stability counter.
  - The debounced level updates only after DEB_CNT consecutive equal synchronised samples.
  - Press event = debounced 1->0, a one-cycle pulse.
  - Latency from pin to event: DEB_CNT+3 cycles.
- Same-cycle press priority: sw0 > sw1 > sw2. Lower-priority events in that cycle are dropped. sw3 is independent of this priority.
- Mode FSM:
  - sw0 event cycles CLOCK->SETUP->ALARM->CLOCK.
  - Every mode change forces o_position=0.
  - sw1 event toggles o_position in any mode.
  - sw3 event toggles o_alarm_en.
- Tick:
  - Counter runs 0..TICK_DIV-1; tick pulses in the cycle the counter equals TICK_DIV-1, then it wraps to 0.
  - In SETUP the counter is held at 0 and no tick is issued.
  - After leaving SETUP, the first tick comes TICK_DIV cycles later.
- Increment source: inc = sw2 press event, or an auto-repeat pulse.
- Auto-repeat:
  - While sw2 stays debounced-pressed, a repeat pulse fires RPT_DLY cycles after the press event, then every RPT_PER cycles.
  - Release, or any mode/position change, cancels repeat.
- Enable routing, all registered, so each enable appears 1 cycle after its source:
  - CLOCK: o_sec_inc=tick; o_min_inc=tick & i_sec_max.
  - ALARM: same time routing as CLOCK. In addition, inc goes to o_alarm_sec_inc if position=0, or to o_alarm_min_inc if position=1.
  - SETUP: inc goes to o_sec_inc (pos 0) or o_min_inc (pos 1). No tick-driven enables.
  - Minute wrap past 59 is the counters' job; no hour carry.
- Alarm FSM, states IDLE and RING:
  - IDLE->RING on a rising edge of i_alarm_match (registered compare), when o_alarm_en=1 and mode != SETUP.
  - RING drives o_buzz_en=1.
  - RING->IDLE on any key press event (the event is consumed and has no other effect), on o_alarm_en falling, or after RING_TICKS ticks.
  - Only a new rising edge of match re-triggers, so a level held high does not restart ringing.
- Reset mid-operation: returns immediately to the reset values above; any pending repeat or ring is lost.

Optional Feature:
- Macro CLK_SEQ_SNOOZE_EN.
- Defined:
  - Adds state SNOOZE.
  - sw2 event in RING -> SNOOZE, with o_buzz_en=0 and a snooze tick count.
  - After SNOOZE_TICKS ticks -> RING, with the ring count restarted.
  - Any other key, or o_alarm_en cleared, in SNOOZE -> IDLE.
- Not defined:
  - No SNOOZE state.
  - sw2 in RING stops ringing like any other key.

Test Plan (TICK_DIV=10, DEB_CNT=4, RPT_DLY=20, RPT_PER=5, RING_TICKS=3):
- Reset, then 100 cycles in CLOCK -> o_sec_inc pulses exactly 10 times, 10 cycles apart; o_min_inc=0 while i_sec_max=0, and pulses with the tick when i_sec_max=1.
- sw0 bounced (low 2 cycles, high 1, then low 10) -> exactly one mode step, 00->01; o_position=0; no o_sec_inc for the next 50 cycles.
- SETUP, position=1, sw2 held 40 cycles -> o_min_inc pulses at press+1, then at +20, +25, +30, +35; o_sec_inc=0 throughout.
- ALARM, o_alarm_en=1, i_alarm_match rises -> o_buzz_en=1 for 3 ticks then 0; match held high does not re-trigger; a repeat with o_alarm_en=0 leaves o_buzz_en=0.
- sw0 and sw2 events in the same cycle in SETUP -> mode goes to 10; no inc pulse.
- With CLK_SEQ_SNOOZE_EN: sw2 in RING -> o_buzz_en=0, returns to 1 after SNOOZE_TICKS ticks; sw1 during SNOOZE -> IDLE.

Source files
------------

// File: rtl/clock_seq_ctrl.sv
// Sequencer for the min:sec clock: key debounce, mode/position FSM, 1 s tick, sw2 auto-repeat and alarm ring.
// Define CLK_SEQ_SNOOZE_EN to add the alarm SNOOZE state entered by sw2 while ringing.
module clock_seq_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CNT    = 1000000,
  parameter int RPT_DLY    = 25000000,
  parameter int RPT_PER    = 5000000,
  parameter int RING_TICKS = 60
`ifdef CLK_SEQ_SNOOZE_EN
  ,
  parameter int SNOOZE_TICKS = 300
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sw3,
  input  logic       i_sec_max,
  input  logic       i_alarm_match,
  output logic [1:0] o_mode,
  output logic       o_position,
  output logic       o_alarm_en,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_alarm_sec_inc,
  output logic       o_alarm_min_inc,
  output logic       o_buzz_en
);

  localparam int DEB_W   = $clog2(DEB_CNT + 1);
  localparam int TICK_W  = $clog2(TICK_DIV + 1);
  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam int RING_W  = $clog2(RING_TICKS + 1);
`ifdef CLK_SEQ_SNOOZE_EN
  localparam int SNZ_W   = $clog2(SNOOZE_TICKS + 1);
`endif

  typedef enum logic [1:0] {M_CLOCK = 2'b00, M_SETUP = 2'b01, M_ALARM = 2'b10} mode_t;
`ifdef CLK_SEQ_SNOOZE_EN
  typedef enum logic [1:0] {A_IDLE, A_RING, A_SNOOZE} alarm_t;
`else
  typedef enum logic {A_IDLE, A_RING} alarm_t;
`endif

  mode_t             mode, next_mode;
  alarm_t            alarm_state;
  logic [3:0]        key_raw, sync1, sync2, deb, deb_q, press;
  logic [DEB_W-1:0]  deb_cnt [4];
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              rpt_active, rpt_first, rpt_pulse;
  logic [RPT_W-1:0]  rpt_cnt, rpt_target;
  logic              ringing, ev0, ev1, ev2, ev3, inc;
  logic              match_r, match_rr, match_rise;
  logic [RING_W-1:0] ring_cnt;
`ifdef CLK_SEQ_SNOOZE_EN
  logic [SNZ_W-1:0]  snooze_cnt;
`endif

  assign key_raw = {i_sw3, i_sw2, i_sw1, i_sw0};
  assign o_mode  = mode;

  // Keys are active-low; a level is accepted after DEB_CNT equal samples, press = accepted 1->0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      deb   <= '1;
      deb_q <= '1;
      press <= '0;
      for (int k = 0; k < 4; k++) deb_cnt[k] <= '0;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      deb_q <= deb;
      press <= deb_q & ~deb;
      for (int k = 0; k < 4; k++) begin
        if (sync2[k] == deb[k]) begin
          deb_cnt[k] <= '0;
        end else if (deb_cnt[k] == DEB_W'(DEB_CNT - 1)) begin
          deb[k]     <= sync2[k];
          deb_cnt[k] <= '0;
        end else begin
          deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
        end
      end
    end
  end

  // While the alarm sounds every key press only silences it
  assign ringing    = (alarm_state != A_IDLE);
  assign ev0        = press[0] & ~ringing;
  assign ev1        = press[1] & ~press[0] & ~ringing;
  assign ev2        = press[2] & ~press[1] & ~press[0] & ~ringing;
  assign ev3        = press[3] & ~ringing;
  assign tick       = (mode != M_SETUP) && (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign rpt_target = rpt_first ? RPT_W'(RPT_DLY) : RPT_W'(RPT_PER);
  assign rpt_pulse  = rpt_active & ~deb[2] & (rpt_cnt == rpt_target);
  assign inc        = ev2 | rpt_pulse;
  assign match_rise = match_r & ~match_rr;

  always_comb begin
    next_mode = M_CLOCK;
    case (mode)
      M_CLOCK: next_mode = M_SETUP;
      M_SETUP: next_mode = M_ALARM;
      default: next_mode = M_CLOCK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tick_cnt <= '0;
    else if (mode == M_SETUP)  tick_cnt <= '0;
    else if (tick)             tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + TICK_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode            <= M_CLOCK;
      o_position      <= 1'b0;
      o_alarm_en      <= 1'b0;
      rpt_active      <= 1'b0;
      rpt_first       <= 1'b0;
      rpt_cnt         <= '0;
      o_sec_inc       <= 1'b0;
      o_min_inc       <= 1'b0;
      o_alarm_sec_inc <= 1'b0;
      o_alarm_min_inc <= 1'b0;
    end else begin
      if (ev0) begin
        mode       <= next_mode;
        o_position <= 1'b0;
      end else if (ev1) begin
        o_position <= ~o_position;
      end
      if (ev3) o_alarm_en <= ~o_alarm_en;

      // Repeat count starts at the press event, so the first pulse lands RPT_DLY cycles after it
      if (ev0 || ev1 || deb[2]) begin
        rpt_active <= 1'b0;
      end else if (ev2) begin
        rpt_active <= 1'b1;
        rpt_first  <= 1'b1;
        rpt_cnt    <= RPT_W'(1);
      end else if (rpt_active) begin
        if (rpt_pulse) begin
          rpt_first <= 1'b0;
          rpt_cnt   <= RPT_W'(1);
        end else begin
          rpt_cnt   <= rpt_cnt + RPT_W'(1);
        end
      end

      o_sec_inc       <= (mode != M_SETUP && tick) || (mode == M_SETUP && inc && !o_position);
      o_min_inc       <= (mode != M_SETUP && tick && i_sec_max) || (mode == M_SETUP && inc && o_position);
      o_alarm_sec_inc <= (mode == M_ALARM) && inc && !o_position;
      o_alarm_min_inc <= (mode == M_ALARM) && inc && o_position;
    end
  end

  // Alarm FSM; only a fresh rising edge of the match level starts ringing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_state <= A_IDLE;
      ring_cnt    <= '0;
      o_buzz_en   <= 1'b0;
      match_r     <= 1'b0;
      match_rr    <= 1'b0;
`ifdef CLK_SEQ_SNOOZE_EN
      snooze_cnt  <= '0;
`endif
    end else begin
      match_r  <= i_alarm_match;
      match_rr <= match_r;
      case (alarm_state)
        A_IDLE: begin
          if (match_rise && o_alarm_en && mode != M_SETUP) begin
            alarm_state <= A_RING;
            ring_cnt    <= '0;
            o_buzz_en   <= 1'b1;
          end
        end
        A_RING: begin
`ifdef CLK_SEQ_SNOOZE_EN
          if (press == 4'b0100) begin
            alarm_state <= A_SNOOZE;
            snooze_cnt  <= '0;
            o_buzz_en   <= 1'b0;
          end else
`endif
          if ((|press) || !o_alarm_en) begin
            alarm_state <= A_IDLE;
            o_buzz_en   <= 1'b0;
          end else if (tick) begin
            if (ring_cnt == RING_W'(RING_TICKS - 1)) begin
              alarm_state <= A_IDLE;
              o_buzz_en   <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + RING_W'(1);
            end
          end
        end
`ifdef CLK_SEQ_SNOOZE_EN
        A_SNOOZE: begin
          if ((|(press & 4'b1011)) || !o_alarm_en) begin
            alarm_state <= A_IDLE;
            o_buzz_en   <= 1'b0;
          end else if (tick) begin
            if (snooze_cnt == SNZ_W'(SNOOZE_TICKS - 1)) begin
              alarm_state <= A_RING;
              ring_cnt    <= '0;
              o_buzz_en   <= 1'b1;
            end else begin
              snooze_cnt <= snooze_cnt + SNZ_W'(1);
            end
          end
        end
`endif
        default: begin
          alarm_state <= A_IDLE;
          o_buzz_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_seq_ctrl.sv
// Self-checking bench for clock_seq_ctrl with small timing parameters; expected pulse times go through a queue.
// Build with CLK_SEQ_SNOOZE_EN defined to also exercise the snooze state.
`timescale 1ns/1ps
module tb_clock_seq_ctrl;

  localparam int TICK_DIV   = 10;
  localparam int DEB_CNT    = 4;
  localparam int RPT_DLY    = 20;
  localparam int RPT_PER    = 5;
  localparam int RING_TICKS = 3;
`ifdef CLK_SEQ_SNOOZE_EN
  localparam int SNOOZE_TICKS = 3;
`endif
  // pin edge -> press event (DEB_CNT+3) -> registered enable (+1)
  localparam int LAT = DEB_CNT + 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw0, sw1, sw2, sw3;
  logic       sec_max, alarm_match;
  logic [1:0] mode;
  logic       position, alarm_en, sec_inc, min_inc, alarm_sec_inc, alarm_min_inc, buzz_en;

  int cyc = 0;
  int check_count = 0;
  int pass_count = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clock_seq_ctrl #(
    .TICK_DIV(TICK_DIV), .DEB_CNT(DEB_CNT), .RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .RING_TICKS(RING_TICKS)
`ifdef CLK_SEQ_SNOOZE_EN
    , .SNOOZE_TICKS(SNOOZE_TICKS)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sw0(sw0), .i_sw1(sw1), .i_sw2(sw2), .i_sw3(sw3),
    .i_sec_max(sec_max), .i_alarm_match(alarm_match),
    .o_mode(mode), .o_position(position), .o_alarm_en(alarm_en),
    .o_sec_inc(sec_inc), .o_min_inc(min_inc),
    .o_alarm_sec_inc(alarm_sec_inc), .o_alarm_min_inc(alarm_min_inc),
    .o_buzz_en(buzz_en)
  );

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       sw0 = v;
      1:       sw1 = v;
      2:       sw2 = v;
      default: sw3 = v;
    endcase
  endtask

  // Hold a key low, release it, then wait until the release has been debounced
  task automatic press_key(input int k, input int hold);
    set_key(k, 1'b0);
    repeat (hold) @(negedge clk);
    set_key(k, 1'b1);
    repeat (DEB_CNT + 8) @(negedge clk);
  endtask

  task automatic wait_buzz(input logic level, input int limit);
    int w;
    w = 0;
    while (buzz_en !== level && w < limit) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {sw0, sw1, sw2, sw3} = 4'b1111;
    sec_max = 1'b0;
    alarm_match = 1'b0;
    repeat (3) @(negedge clk);
    check_count++;
    if (mode !== 2'b00) $display("[TB] FAIL reset_mode: got %0d expected 0", mode); else pass_count++;
    check_count++;
    if ({position, alarm_en, buzz_en} !== 3'b000)
      $display("[TB] FAIL reset_flags: got %b expected 000", {position, alarm_en, buzz_en});
    else pass_count++;
    check_count++;
    if ({sec_inc, min_inc, alarm_sec_inc, alarm_min_inc} !== 4'b0000)
      $display("[TB] FAIL reset_incs: got %b expected 0000", {sec_inc, min_inc, alarm_sec_inc, alarm_min_inc});
    else pass_count++;
  endtask

  task automatic test_tick();
    int t0, pulses, min_pulses, mism, e;
    rst_n = 1'b1;
    t0 = cyc;
    exp_q.delete();
    exp_q.push_back(t0 + TICK_DIV);
    pulses = 0;
    min_pulses = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (min_inc) min_pulses++;
      if (sec_inc) begin
        pulses++;
        check_count++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (cyc !== e) $display("[TB] FAIL tick_time: got cycle %0d expected %0d", cyc - t0, e - t0);
        else pass_count++;
        exp_q.push_back(cyc + TICK_DIV);
      end
    end
    exp_q.delete();
    check_count++;
    if (pulses !== 10) $display("[TB] FAIL tick_count: got %0d expected 10", pulses); else pass_count++;
    check_count++;
    if (min_pulses !== 0) $display("[TB] FAIL min_no_carry: got %0d expected 0", min_pulses); else pass_count++;
    sec_max = 1'b1;
    min_pulses = 0;
    mism = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (min_inc) min_pulses++;
      if (min_inc !== sec_inc) mism++;
    end
    sec_max = 1'b0;
    check_count++;
    if (min_pulses !== 3 || mism !== 0)
      $display("[TB] FAIL min_carry: got %0d pulses %0d misaligned expected 3 pulses 0 misaligned", min_pulses, mism);
    else pass_count++;
  endtask

  task automatic test_bounce();
    int changes, stray;
    logic [1:0] last_mode;
    changes = 0;
    stray = 0;
    last_mode = mode;
    for (int i = 0; i < 40; i++) begin
      sw0 = (i == 2 || i >= 13) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (mode !== last_mode) changes++;
      last_mode = mode;
    end
    check_count++;
    if (changes !== 1 || mode !== 2'b01)
      $display("[TB] FAIL bounce_mode: got %0d steps mode %0d expected 1 step mode 1", changes, mode);
    else pass_count++;
    check_count++;
    if (position !== 1'b0) $display("[TB] FAIL bounce_pos: got %0d expected 0", position); else pass_count++;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (sec_inc) stray++;
    end
    check_count++;
    if (stray !== 0) $display("[TB] FAIL setup_no_tick: got %0d expected 0", stray); else pass_count++;
  endtask

  task automatic test_repeat();
    int n, e, sec_bad;
    press_key(1, 10);
    check_count++;
    if (position !== 1'b1) $display("[TB] FAIL setup_pos: got %0d expected 1", position); else pass_count++;
    exp_q.delete();
    n = cyc;
    sw2 = 1'b0;
    exp_q.push_back(n + LAT);
    for (int r = 0; r < 4; r++) exp_q.push_back(n + LAT + RPT_DLY + r * RPT_PER);
    sec_bad = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (sec_inc) sec_bad++;
      if (min_inc) begin
        check_count++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        if (cyc !== e) $display("[TB] FAIL repeat_time: got cycle %0d expected %0d", cyc - n, e - n);
        else pass_count++;
      end
      if (i == 40) sw2 = 1'b1;
    end
    check_count++;
    if (exp_q.size() !== 0) $display("[TB] FAIL repeat_missing: got %0d left expected 0", exp_q.size());
    else pass_count++;
    check_count++;
    if (sec_bad !== 0) $display("[TB] FAIL repeat_sec: got %0d expected 0", sec_bad); else pass_count++;
    exp_q.delete();
  endtask

  task automatic test_same_cycle();
    int inc_bad, early_tick;
    inc_bad = 0;
    early_tick = 0;
    sw0 = 1'b0;
    sw2 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (min_inc || alarm_sec_inc || alarm_min_inc) inc_bad++;
      if (i <= 15 && sec_inc) early_tick++;
      if (i == 30) begin
        sw0 = 1'b1;
        sw2 = 1'b1;
      end
    end
    repeat (DEB_CNT + 4) @(negedge clk);
    check_count++;
    if (mode !== 2'b10) $display("[TB] FAIL prio_mode: got %0d expected 2", mode); else pass_count++;
    check_count++;
    if (position !== 1'b0) $display("[TB] FAIL prio_pos: got %0d expected 0", position); else pass_count++;
    check_count++;
    if (inc_bad !== 0 || early_tick !== 0)
      $display("[TB] FAIL prio_no_inc: got %0d/%0d expected 0/0", inc_bad, early_tick);
    else pass_count++;
  endtask

  task automatic test_alarm_routing();
    int n, e, wrong;
    logic hit, miss;
    for (int p = 0; p < 2; p++) begin
      if (p == 1) press_key(1, 10);
      exp_q.delete();
      wrong = 0;
      n = cyc;
      sw2 = 1'b0;
      exp_q.push_back(n + LAT);
      for (int i = 1; i <= 25; i++) begin
        @(negedge clk);
        hit  = (p == 1) ? alarm_min_inc : alarm_sec_inc;
        miss = (p == 1) ? alarm_sec_inc : alarm_min_inc;
        if (miss) wrong++;
        if (hit) begin
          check_count++;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
          if (cyc !== e) $display("[TB] FAIL alarm_inc_time p%0d: got cycle %0d expected %0d", p, cyc - n, e - n);
          else pass_count++;
        end
        if (i == 10) sw2 = 1'b1;
      end
      check_count++;
      if (exp_q.size() !== 0 || wrong !== 0)
        $display("[TB] FAIL alarm_inc_route p%0d: got %0d missing %0d wrong expected 0/0", p, exp_q.size(), wrong);
      else pass_count++;
    end
    exp_q.delete();
    press_key(1, 10);
  endtask

  task automatic test_alarm();
    int dur, rings;
    logic fall_tick;
    press_key(3, 10);
    check_count++;
    if (alarm_en !== 1'b1) $display("[TB] FAIL alarm_arm: got %0d expected 1", alarm_en); else pass_count++;
    alarm_match = 1'b1;
    wait_buzz(1'b1, 10);
    check_count++;
    if (buzz_en !== 1'b1) $display("[TB] FAIL ring_start: got %0d expected 1", buzz_en); else pass_count++;
    dur = 0;
    while (buzz_en === 1'b1 && dur < 60) begin
      dur++;
      @(negedge clk);
    end
    fall_tick = sec_inc;
    check_count++;
    if (dur < 2 * TICK_DIV + 1 || dur > RING_TICKS * TICK_DIV)
      $display("[TB] FAIL ring_len: got %0d cycles expected %0d..%0d", dur, 2 * TICK_DIV + 1, RING_TICKS * TICK_DIV);
    else pass_count++;
    check_count++;
    if (fall_tick !== 1'b1) $display("[TB] FAIL ring_end_on_tick: got %0d expected 1", fall_tick); else pass_count++;
    rings = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (buzz_en) rings++;
    end
    check_count++;
    if (rings !== 0) $display("[TB] FAIL held_match: got %0d expected 0", rings); else pass_count++;
    alarm_match = 1'b0;
    repeat (3) @(negedge clk);
    alarm_match = 1'b1;
    wait_buzz(1'b1, 10);
    sw1 = 1'b0;
    repeat (10) @(negedge clk);
    check_count++;
    if (buzz_en !== 1'b0) $display("[TB] FAIL key_stop: got %0d expected 0", buzz_en); else pass_count++;
    sw1 = 1'b1;
    repeat (10) @(negedge clk);
    check_count++;
    if (position !== 1'b0) $display("[TB] FAIL key_consumed: got %0d expected 0", position); else pass_count++;
    alarm_match = 1'b0;
    press_key(3, 10);
    check_count++;
    if (alarm_en !== 1'b0) $display("[TB] FAIL alarm_disarm: got %0d expected 0", alarm_en); else pass_count++;
    alarm_match = 1'b1;
    rings = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (buzz_en) rings++;
    end
    check_count++;
    if (rings !== 0) $display("[TB] FAIL disarmed_ring: got %0d expected 0", rings); else pass_count++;
    alarm_match = 1'b0;
    repeat (3) @(negedge clk);
  endtask

`ifdef CLK_SEQ_SNOOZE_EN
  task automatic test_snooze();
    int w, rings, stray;
    stray = 0;
    press_key(3, 10);
    alarm_match = 1'b1;
    wait_buzz(1'b1, 10);
    sw2 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (alarm_sec_inc) stray++;
    end
    sw2 = 1'b1;
    check_count++;
    if (buzz_en !== 1'b0) $display("[TB] FAIL snooze_enter: got %0d expected 0", buzz_en); else pass_count++;
    w = 0;
    while (buzz_en !== 1'b1 && w < SNOOZE_TICKS * TICK_DIV + 20) begin
      @(negedge clk);
      if (alarm_sec_inc) stray++;
      w++;
    end
    check_count++;
    if (buzz_en !== 1'b1 || w < (SNOOZE_TICKS - 1) * TICK_DIV)
      $display("[TB] FAIL snooze_return: got buzz %0d after %0d cycles expected 1 after >=%0d", buzz_en, w, (SNOOZE_TICKS - 1) * TICK_DIV);
    else pass_count++;
    sw2 = 1'b0;
    repeat (10) @(negedge clk);
    sw2 = 1'b1;
    sw1 = 1'b0;
    repeat (10) @(negedge clk);
    sw1 = 1'b1;
    rings = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (buzz_en) rings++;
      if (alarm_sec_inc) stray++;
    end
    check_count++;
    if (rings !== 0) $display("[TB] FAIL snooze_cancel: got %0d expected 0", rings); else pass_count++;
    check_count++;
    if (stray !== 0 || position !== 1'b0)
      $display("[TB] FAIL snooze_consumed: got %0d incs pos %0d expected 0 pos 0", stray, position);
    else pass_count++;
    alarm_match = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`endif

  task automatic test_reset_mid();
    check_count++;
    if (mode !== 2'b10) $display("[TB] FAIL pre_reset_mode: got %0d expected 2", mode); else pass_count++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_count++;
    if ({mode, position, alarm_en, buzz_en} !== 5'b00000)
      $display("[TB] FAIL async_reset: got %b expected 00000", {mode, position, alarm_en, buzz_en});
    else pass_count++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_count++;
    if (mode !== 2'b00 || sec_inc !== 1'b0) $display("[TB] FAIL post_reset: got mode %0d expected 0", mode);
    else pass_count++;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("%0d/%0d checks passed", pass_count, check_count + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_tick();
    test_bounce();
    test_repeat();
    test_same_cycle();
    test_alarm_routing();
    test_alarm();
`ifdef CLK_SEQ_SNOOZE_EN
    test_snooze();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
